// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin grant scheduler.
// State encoding, default sizing and the one-hot grant helper.
package rr_arb_pkg;

  localparam int unsigned DEFAULT_N        = 3;
  localparam int unsigned DEFAULT_HOLD_MAX = 8;
  localparam int unsigned MAX_N            = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT   = 2'b01,
    RELEASE = 2'b10
  } state_e;

  // One-hot vector for a requester index; callers truncate to N bits.
  function automatic logic [MAX_N-1:0] onehot(input logic [2:0] idx);
    onehot = MAX_N'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_grant_scheduler_if.sv
// Request/grant bus between the requesting FSMs and the scheduler.
// master = requester side, slave = scheduler side.
interface rr_grant_scheduler_if #(
  parameter int unsigned N = rr_arb_pkg::DEFAULT_N
);

  localparam int unsigned IDW = $clog2(N);

  logic [N-1:0]   req;
  logic [N-1:0]   grant;
  logic [IDW-1:0] owner_id;
  logic           busy;
  logic           timeout;

  modport master (
    output req,
    input  grant,
    input  owner_id,
    input  busy,
    input  timeout
  );

  modport slave (
    input  req,
    output grant,
    output owner_id,
    output busy,
    output timeout
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first set req bit at or above ptr, mod N.
module rr_pick #(
  parameter int unsigned N = rr_arb_pkg::DEFAULT_N
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 valid,
  output logic [$clog2(N)-1:0] idx
);

  localparam int unsigned IDW = $clog2(N);

  int unsigned    cand;
  logic [IDW-1:0] cand_idx;

  always_comb begin
    valid    = 1'b0;
    idx      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = 32'(ptr) + i;
      if (cand >= N) cand = cand - N;
      cand_idx = IDW'(cand);
      if (!valid && req[cand_idx]) begin
        valid = 1'b1;
        idx   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/rr_grant_scheduler.sv
// Round-robin grant scheduler with a one-cycle release gap between grants.
// Optional hold-limit preemption is compiled in with RR_GRANT_TIMEOUT_EN.
module rr_grant_scheduler
  import rr_arb_pkg::*;
#(
  parameter int unsigned N        = DEFAULT_N,
  parameter int unsigned HOLD_MAX = DEFAULT_HOLD_MAX
) (
  input  logic               clk,
  input  logic               reset,
  rr_grant_scheduler_if.slave bus
);

  localparam int unsigned IDW = $clog2(N);

  if (N < 2 || N > MAX_N) begin : g_bad_n
    $error("rr_grant_scheduler: N must be in 2..8");
  end
  if (HOLD_MAX < 1) begin : g_bad_hold
    $error("rr_grant_scheduler: HOLD_MAX must be at least 1");
  end

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [IDW-1:0] owner_id_q, owner_id_d;
  logic           busy_q, busy_d;
  logic [IDW-1:0] next_ptr;
  logic           pick_valid;
  logic [IDW-1:0] pick_idx;

`ifdef RR_GRANT_TIMEOUT_EN
  localparam int unsigned HW = $clog2(HOLD_MAX + 1);
  logic [HW-1:0] hold_q, hold_d;
  logic          timeout_q, timeout_d;
`endif

  rr_pick #(.N(N)) u_pick (
    .req   (bus.req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign next_ptr = (owner_q == IDW'(N - 1)) ? '0 : owner_q + IDW'(1);

  // Next-state, pointer/owner update and registered output values.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
`ifdef RR_GRANT_TIMEOUT_EN
    hold_d    = hold_q;
    timeout_d = 1'b0;
`endif
    unique case (state_q)
      IDLE, RELEASE: begin
        if (pick_valid) begin
          state_d = GRANT;
          owner_d = pick_idx;
`ifdef RR_GRANT_TIMEOUT_EN
          hold_d  = '0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        // An owner drop wins over a coincident hold-limit expiry.
        if (!bus.req[owner_q]) begin
          state_d = RELEASE;
          ptr_d   = next_ptr;
`ifdef RR_GRANT_TIMEOUT_EN
        end else if (hold_q == HW'(HOLD_MAX - 1)) begin
          state_d   = RELEASE;
          ptr_d     = next_ptr;
          timeout_d = 1'b1;
        end else begin
          hold_d = hold_q + HW'(1);
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    grant_d    = (state_d == GRANT) ? N'(onehot(3'(owner_d))) : '0;
    owner_id_d = (state_d == GRANT) ? owner_d : '0;
    busy_d     = (state_d == GRANT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      grant_q    <= '0;
      owner_id_q <= '0;
      busy_q     <= 1'b0;
`ifdef RR_GRANT_TIMEOUT_EN
      hold_q     <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      grant_q    <= grant_d;
      owner_id_q <= owner_id_d;
      busy_q     <= busy_d;
`ifdef RR_GRANT_TIMEOUT_EN
      hold_q     <= hold_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign bus.grant    = grant_q;
  assign bus.owner_id = owner_id_q;
  assign bus.busy     = busy_q;
`ifdef RR_GRANT_TIMEOUT_EN
  assign bus.timeout  = timeout_q;
`else
  assign bus.timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Directed bench for rr_grant_scheduler (N=3, HOLD_MAX=8).
// Hold-limit checks are active when RR_GRANT_TIMEOUT_EN is defined.
module tb_rr_grant_scheduler;

  localparam int unsigned N    = 3;
  localparam int unsigned HOLD = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  rr_grant_scheduler_if #(.N(N)) bus ();

  rr_grant_scheduler #(.N(N), .HOLD_MAX(HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] g, input logic [1:0] own,
                         input logic b, input logic to);
    chk({tag, ".grant"},    32'(bus.grant),    32'(g));
    chk({tag, ".owner_id"}, 32'(bus.owner_id), 32'(own));
    chk({tag, ".busy"},     32'(bus.busy),     32'(b));
    chk({tag, ".timeout"},  32'(bus.timeout),  32'(to));
  endtask

  initial begin
    bus.req = 3'b000;
    step(); step();
    chk_all("reset", 3'b000, 2'd0, 1'b0, 1'b0);
    reset = 1'b0;

    // First grant: ptr=0, requester 0 wins over 2
    bus.req = 3'b101; step();
    chk_all("g0_first", 3'b001, 2'd0, 1'b1, 1'b0);
    step();
    chk_all("g0_hold", 3'b001, 2'd0, 1'b1, 1'b0);

    // Owner drop: one dead cycle, then requester 2
    bus.req = 3'b100; step();
    chk_all("rel0", 3'b000, 2'd0, 1'b0, 1'b0);
    step();
    chk_all("g2", 3'b100, 2'd2, 1'b1, 1'b0);
    bus.req = 3'b000; step();
    chk_all("rel2", 3'b000, 2'd0, 1'b0, 1'b0);
    step();
    chk_all("idle_a", 3'b000, 2'd0, 1'b0, 1'b0);

    // All requesting: rotation 0,1,2,0 (ptr=0 after requester 2 released)
    bus.req = 3'b111; step(); chk_all("rot_g0", 3'b001, 2'd0, 1'b1, 1'b0);
    step();                   chk("rot_g0b", 32'(bus.grant), 32'h1);
    bus.req = 3'b110; step(); chk_all("rot_r0", 3'b000, 2'd0, 1'b0, 1'b0);
    bus.req = 3'b111; step(); chk_all("rot_g1", 3'b010, 2'd1, 1'b1, 1'b0);
    step();                   chk("rot_g1b", 32'(bus.grant), 32'h2);
    bus.req = 3'b101; step(); chk_all("rot_r1", 3'b000, 2'd0, 1'b0, 1'b0);
    bus.req = 3'b111; step(); chk_all("rot_g2", 3'b100, 2'd2, 1'b1, 1'b0);
    step();                   chk("rot_g2b", 32'(bus.grant), 32'h4);
    bus.req = 3'b011; step(); chk_all("rot_r2", 3'b000, 2'd0, 1'b0, 1'b0);
    bus.req = 3'b111; step(); chk_all("rot_g0w", 3'b001, 2'd0, 1'b1, 1'b0);
    bus.req = 3'b000; step(); chk("rot_rel", 32'(bus.grant), 32'h0);
    step();                   chk("idle_b", 32'(bus.busy), 32'h0);

    // ptr=1: lone requester 2 wins, then req[1] withdrawn during RELEASE
    bus.req = 3'b100; step(); chk_all("wd_g2", 3'b100, 2'd2, 1'b1, 1'b0);
    bus.req = 3'b010; step(); chk_all("wd_rel", 3'b000, 2'd0, 1'b0, 1'b0);
    bus.req = 3'b001; step(); chk_all("wd_g0", 3'b001, 2'd0, 1'b1, 1'b0);
    bus.req = 3'b000; step(); chk("wd_rel0", 32'(bus.grant), 32'h0);
    step();

    // ptr=1: grant requester 1, then reset mid-GRANT
    bus.req = 3'b010; step(); chk_all("rst_g1", 3'b010, 2'd1, 1'b1, 1'b0);
    step();
    reset = 1'b1; step();
    chk_all("rst_mid", 3'b000, 2'd0, 1'b0, 1'b0);
    reset = 1'b0; bus.req = 3'b011; step();
    chk_all("rst_ptr0", 3'b001, 2'd0, 1'b1, 1'b0);

`ifdef RR_GRANT_TIMEOUT_EN
    // Requester 0 keeps its request: 8 grant cycles, then preempted
    for (int i = 1; i < int'(HOLD); i++) begin
      step(); chk("to_hold0", 32'(bus.grant), 32'h1);
    end
    step(); chk_all("to_pulse0", 3'b000, 2'd0, 1'b0, 1'b1);
    step(); chk_all("to_g1", 3'b010, 2'd1, 1'b1, 1'b0);

    // Only requester 1: preempted, then re-granted after RELEASE
    bus.req = 3'b010;
    for (int i = 1; i < int'(HOLD); i++) begin
      step(); chk("to_hold1", 32'(bus.grant), 32'h2);
    end
    step(); chk_all("to_pulse1", 3'b000, 2'd0, 1'b0, 1'b1);
    step(); chk_all("to_regrant1", 3'b010, 2'd1, 1'b1, 1'b0);

    // Owner drop on the hold-limit cycle is a plain release
    for (int i = 1; i < int'(HOLD); i++) begin
      step(); chk("to_hold1b", 32'(bus.grant), 32'h2);
    end
    bus.req = 3'b000; step();
    chk_all("to_coincide", 3'b000, 2'd0, 1'b0, 1'b0);
    step(); chk("to_idle", 32'(bus.timeout), 32'h0);
`else
    // Without the watchdog a grant lasts as long as the request
    for (int i = 0; i < 3 * int'(HOLD); i++) begin
      step();
      chk("nt_hold", 32'(bus.grant), 32'h1);
      chk("nt_timeout", 32'(bus.timeout), 32'h0);
    end
    bus.req = 3'b000; step();
    chk_all("nt_rel", 3'b000, 2'd0, 1'b0, 1'b0);
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
